attack_resolver: RTL
====================

# attack_resolver

Defender-side responder for the battleship attack interface. It takes the debounced attack button and the 3-bit row/column coordinates, and checks each shot against the placed-ship board (`col1..col5` from the placement stage). It accumulates hit and miss maps and reports the outcome of each shot. Its `colHit1..colHit5` outputs feed the matrix controller's hit inputs; its status outputs drive the game-flow logic (win/lose).

## Interface
- `ROWS`, 7: rows per column; board bit r = row r.
- `COLS`, 5: number of columns; `columns_attack` value c selects `col(c+1)`.
- `MAX_SHOTS`, 20: number of accepted shots that ends the game as a loss.
- `clk` in 1: system clock (381 Hz divided clock in the top level).
- `reset` in 1: asynchronous, active-high; clears all maps, counters and flags.
- `attack_button` in 1: debounced level; rising edge requests one shot.
- `rows_attack` in 3: target row, valid 0..6.
- `columns_attack` in 3: target column, valid 0..4.
- `col1`..`col5` in 7 each: placed-ship board, 1 = ship cell. Must be stable while the FSM is outside IDLE.
- `colHit1`..`colHit5` out 7 each: cells shot and hit.
- `colMiss1`..`colMiss5` out 7 each: cells shot and missed.
- `result` out 2: last shot outcome. 00 none, 01 miss, 10 hit, 11 rejected (invalid or repeated).
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `shots_count` out 5: accepted shots, saturating at `MAX_SHOTS`.
- `hits_count` out 6: number of hit cells.
- `game_won` out 1: sticky; every ship cell has been hit and the board is nonzero.
- `game_lost` out 1: sticky; `shots_count == MAX_SHOTS` and not won.

## Operation
- FSM states and transitions:
  - IDLE: a rising edge on `attack_button` latches the coordinates and moves to CHECK.
  - CHECK: classifies the shot, moves to UPDATE.
  - UPDATE: writes the maps, counters and `result`, pulses `result_valid`, moves to IDLE.
  - OVER: entered from UPDATE when `game_won` or `game_lost` becomes true; exits only on `reset`.
- Rising edge detection uses a registered copy of `attack_button`. An edge outside IDLE is discarded; it is not queued.
- Classification in CHECK, in priority order:
  - invalid: row ≥ 7 or col ≥ 5;
  - repeat: the target bit is already set in the hit or miss map;
  - hit: the board bit is 1;
  - otherwise miss.
- Invalid and repeat shots set `result`=11 and do not change any map or counter.
- Hit sets the hit-map bit and increments `hits_count` and `shots_count`. Miss sets the miss-map bit and increments `shots_count`.
- `game_won` is evaluated in UPDATE: for every column, (hit & board) == board, and board ≠ 0. Win takes priority if the last allowed shot is also the winning hit.
- Reset values: all maps 0, counters 0, `result`=00, `result_valid`=0, `game_won`=`game_lost`=0, state IDLE.

## Timing
- Button rises before edge E. The edge is detected at E, CHECK runs at E+1, and UPDATE at E+2.
- Maps, counters and `result` become visible, and `result_valid` is high, during the cycle after E+2.
- Minimum spacing between accepted shots is 3 clocks. Presses closer than that are ignored.
- Coordinates are sampled only at the detection edge. Later changes do not affect the shot in flight.
- Reset asserted mid-operation aborts the shot immediately, with no partial map write.
- The button held high across reset release does not fire; a new rising edge is required.

## Structure
- Shared package `board_pkg` holds:
  - constants `ROWS`, `COLS`, `MAX_SHOTS`;
  - the `result` encodings (NONE, MISS, HIT, REJECT);
  - the FSM state encoding (IDLE, CHECK, UPDATE, OVER).
- One sub-module: `rising_edge_detector` (clk, reset, in, pulse). The team reuses it for the other buttons.

## Test plan
- Board col1=0000011, all other columns 0. Attack (r0,c0): `result`=10, `colHit1`=0000001, `shots_count`=1, `hits_count`=1.
- Same board, attack (r2,c3): `result`=01, `colMiss4`=0000100, `hits_count` unchanged at 1.
- Attack (r0,c0) again, then (r7,c2), then (r1,c5): each gives `result`=11, with no change to counters or maps.
- Attack (r0,c0) then (r1,c0): `game_won`=1, state OVER. A further press produces no `result_valid` pulse.
- Board with one ship cell, 20 misses: `game_lost`=1 after the 20th, `shots_count`=20. Reset clears all outputs to 0.
- Button pulse 1 clock after an accepted edge is ignored. Reset asserted at E+1 leaves all maps at 0.

Source files
------------

// File: rtl/board_pkg.sv
// Shared battleship board constants, result/state encodings and the win test
// used by the defender-side logic.
package board_pkg;

    localparam int ROWS      = 7;
    localparam int COLS      = 5;
    localparam int MAX_SHOTS = 20;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_MISS   = 2'b01,
        RES_HIT    = 2'b10,
        RES_REJECT = 2'b11
    } result_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CHECK  = 2'b01,
        ST_UPDATE = 2'b10,
        ST_OVER   = 2'b11
    } state_e;

    // Index [c] selects column c+1, bit [r] selects row r.
    typedef logic [COLS-1:0][ROWS-1:0] board_t;

    // True when every ship cell has been hit and at least one ship cell exists.
    function automatic logic fleet_sunk(input board_t hit_map, input board_t ships);
        return ((hit_map & ships) == ships) && (ships != '0);
    endfunction

endpackage

// File: rtl/rising_edge_detector.sv
// Single-cycle pulse on a rising edge of a synchronous level input.
// Reset primes the history high, so a level held across reset never fires.
module rising_edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = in & ~prev_q;

endmodule

// File: rtl/attack_resolver.sv
// Defender-side shot resolver: latches a shot on a button edge, classifies it
// against the placed-ship board and accumulates hit/miss maps and game status.
module attack_resolver
    import board_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       attack_button,
    input  logic [2:0] rows_attack,
    input  logic [2:0] columns_attack,
    input  logic [6:0] col1,
    input  logic [6:0] col2,
    input  logic [6:0] col3,
    input  logic [6:0] col4,
    input  logic [6:0] col5,
    output logic [6:0] colHit1,
    output logic [6:0] colHit2,
    output logic [6:0] colHit3,
    output logic [6:0] colHit4,
    output logic [6:0] colHit5,
    output logic [6:0] colMiss1,
    output logic [6:0] colMiss2,
    output logic [6:0] colMiss3,
    output logic [6:0] colMiss4,
    output logic [6:0] colMiss5,
    output logic [1:0] result,
    output logic       result_valid,
    output logic [4:0] shots_count,
    output logic [5:0] hits_count,
    output logic       game_won,
    output logic       game_lost
);

    localparam logic [2:0] ROW_LIM  = 3'(ROWS);
    localparam logic [2:0] COL_LIM  = 3'(COLS);
    localparam logic [4:0] SHOT_LIM = 5'(MAX_SHOTS);

    board_t  board;
    logic    press;

    state_e  state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    result_e class_q, class_d;
    result_e result_q, result_d;
    logic    result_valid_q, result_valid_d;
    board_t  hit_q, hit_d;
    board_t  miss_q, miss_d;
    logic [4:0] shots_q, shots_d;
    logic [5:0] hits_q, hits_d;
    logic    won_q, won_d;
    logic    lost_q, lost_d;

    logic    cell_valid;
    logic    cell_used;
    logic    cell_ship;
    logic    won_now;

    assign board = {col5, col4, col3, col2, col1};

    rising_edge_detector u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .in    (attack_button),
        .pulse (press)
    );

    // Cell lookups only happen once the coordinates are known to be in range.
    always_comb begin
        cell_valid = (row_q < ROW_LIM) && (col_q < COL_LIM);
        cell_used  = 1'b0;
        cell_ship  = 1'b0;
        if (cell_valid) begin
            cell_used = hit_q[col_q][row_q] | miss_q[col_q][row_q];
            cell_ship = board[col_q][row_q];
        end
    end

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        class_d        = class_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        hit_d          = hit_q;
        miss_d         = miss_q;
        shots_d        = shots_q;
        hits_d         = hits_q;
        won_d          = won_q;
        lost_d         = lost_q;
        won_now        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    row_d   = rows_attack;
                    col_d   = columns_attack;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!cell_valid || cell_used) begin
                    class_d = RES_REJECT;
                end else if (cell_ship) begin
                    class_d = RES_HIT;
                end else begin
                    class_d = RES_MISS;
                end
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                result_d       = class_q;
                result_valid_d = 1'b1;
                if (class_q == RES_HIT || class_q == RES_MISS) begin
                    if (class_q == RES_HIT) begin
                        hit_d[col_q][row_q] = 1'b1;
                        hits_d              = hits_q + 6'd1;
                    end else begin
                        miss_d[col_q][row_q] = 1'b1;
                    end
                    shots_d = (shots_q < SHOT_LIM) ? shots_q + 5'd1 : shots_q;
                end
                // A winning final shot is a win, never a loss.
                won_now = fleet_sunk(hit_d, board);
                won_d   = won_q | won_now;
                lost_d  = lost_q | ((shots_d == SHOT_LIM) && !won_d);
                state_d = (won_d || lost_d) ? ST_OVER : ST_IDLE;
            end
            default: begin
                state_d = ST_OVER;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            row_q          <= '0;
            col_q          <= '0;
            class_q        <= RES_NONE;
            result_q       <= RES_NONE;
            result_valid_q <= 1'b0;
            hit_q          <= '0;
            miss_q         <= '0;
            shots_q        <= '0;
            hits_q         <= '0;
            won_q          <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            class_q        <= class_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            shots_q        <= shots_d;
            hits_q         <= hits_d;
            won_q          <= won_d;
            lost_q         <= lost_d;
        end
    end

    assign colHit1  = hit_q[0];
    assign colHit2  = hit_q[1];
    assign colHit3  = hit_q[2];
    assign colHit4  = hit_q[3];
    assign colHit5  = hit_q[4];
    assign colMiss1 = miss_q[0];
    assign colMiss2 = miss_q[1];
    assign colMiss3 = miss_q[2];
    assign colMiss4 = miss_q[3];
    assign colMiss5 = miss_q[4];

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign shots_count  = shots_q;
    assign hits_count   = hits_q;
    assign game_won     = won_q;
    assign game_lost    = lost_q;

endmodule
